soc_decerr_slave: RTL and testbench

SOC_DECERR_SLAVE -- requirements
Module: soc_decerr_slave

---
 rtl/soc_decerr_slave.sv | 178 +++++++++++++++++
 tb/tb_soc_decerr_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_decerr_slave.sv
// rtl/soc_decerr_slave.sv - default-target AXI slave answering every access with DECERR
module soc_decerr_slave #(
    parameter int unsigned            IdWidth   = 8,
    parameter int unsigned            AddrWidth = 64,
    parameter int unsigned            DataWidth = 64,
    parameter logic [DataWidth-1:0]   RespData  = DataWidth'(64'hBADC_AB1E_DEAD_BEEF)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // write address
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    // write data
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    // write response
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    // read address
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    // read data
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    // error statistics
    output logic [15:0]          err_cnt_o,
    output logic [AddrWidth-1:0] err_addr_o
);

    localparam logic [1:0] DecErr = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DRAIN = 2'd1,
        W_RESP  = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } r_state_e;

    w_state_e             w_state_q, w_state_d;
    r_state_e             r_state_q, r_state_d;
    logic [IdWidth-1:0]   aw_id_q, aw_id_d;
    logic [IdWidth-1:0]   ar_id_q, ar_id_d;
    logic [7:0]           ar_len_q, ar_len_d;
    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;

    logic                 aw_hs;
    logic                 ar_hs;
    logic                 last_beat;
    logic [16:0]          err_sum;

    // Every output is a pure decode of registered state, never of an input.
    assign aw_ready_o = (w_state_q == W_IDLE);
    assign w_ready_o  = (w_state_q == W_DRAIN);
    assign b_valid_o  = (w_state_q == W_RESP);
    assign b_id_o     = aw_id_q;
    assign b_resp_o   = DecErr;

    assign last_beat  = (beat_cnt_q == ar_len_q);
    assign ar_ready_o = (r_state_q == R_IDLE);
    assign r_valid_o  = (r_state_q == R_SEND);
    assign r_last_o   = (r_state_q == R_SEND) && last_beat;
    assign r_id_o     = ar_id_q;
    assign r_data_o   = RespData;
    assign r_resp_o   = DecErr;

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;

    // Write path: accept address, swallow data until the last beat, then respond.
    always_comb begin
        w_state_d = w_state_q;
        aw_id_d   = aw_id_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_valid_i) begin
                    aw_id_d   = aw_id_i;
                    w_state_d = W_DRAIN;
                end
            end
            W_DRAIN: begin
                if (w_valid_i && w_last_i) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path: emit len+1 error beats; the counter stops at len so it never wraps.
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_len_d   = ar_len_q;
        beat_cnt_d = beat_cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_valid_i) begin
                    ar_id_d    = ar_id_i;
                    ar_len_d   = ar_len_i;
                    beat_cnt_d = 8'd0;
                    r_state_d  = R_SEND;
                end
            end
            R_SEND: begin
                if (r_ready_i) begin
                    if (last_beat) begin
                        r_state_d = R_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Error statistics: saturating count, write address takes priority on a tie.
    always_comb begin
        err_sum    = {1'b0, err_cnt_q} + 17'(aw_hs) + 17'(ar_hs);
        err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        err_addr_d = err_addr_q;
        if (aw_hs) begin
            err_addr_d = aw_addr_i;
        end else if (ar_hs) begin
            err_addr_d = ar_addr_i;
        end
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_id_q    <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_id_q    <= aw_id_d;
            ar_id_q    <= ar_id_d;
            ar_len_q   <= ar_len_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_soc_decerr_slave.sv
// tb/tb_soc_decerr_slave.sv - directed self-checking bench for soc_decerr_slave
module tb_soc_decerr_slave;

    localparam logic [63:0] RESP_DATA = 64'hBADC_AB1E_DEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        aw_valid_i, aw_ready_o;
    logic [7:0]  aw_id_i;
    logic [63:0] aw_addr_i;
    logic        w_valid_i, w_ready_o, w_last_i;
    logic        b_valid_o, b_ready_i;
    logic [7:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        ar_valid_i, ar_ready_o;
    logic [7:0]  ar_id_i;
    logic [63:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic        r_valid_o, r_ready_i;
    logic [7:0]  r_id_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic [15:0] err_cnt_o;
    logic [63:0] err_addr_o;

    int n_cmp = 0;
    int n_err = 0;

    soc_decerr_slave dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .aw_id_i    (aw_id_i),
        .aw_addr_i  (aw_addr_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .w_last_i   (w_last_i),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .b_id_o     (b_id_o),
        .b_resp_o   (b_resp_o),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .ar_id_i    (ar_id_i),
        .ar_addr_i  (ar_addr_i),
        .ar_len_i   (ar_len_i),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .r_id_o     (r_id_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_last_o   (r_last_o),
        .err_cnt_o  (err_cnt_o),
        .err_addr_o (err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_aw_ready"}, 64'(aw_ready_o), 64'd1);
        chk({pfx, "_ar_ready"}, 64'(ar_ready_o), 64'd1);
        chk({pfx, "_w_ready"},  64'(w_ready_o),  64'd0);
        chk({pfx, "_b_valid"},  64'(b_valid_o),  64'd0);
        chk({pfx, "_r_valid"},  64'(r_valid_o),  64'd0);
        chk({pfx, "_r_last"},   64'(r_last_o),   64'd0);
        chk({pfx, "_b_resp"},   64'(b_resp_o),   64'd3);
        chk({pfx, "_r_resp"},   64'(r_resp_o),   64'd3);
        chk({pfx, "_b_id"},     64'(b_id_o),     64'd0);
        chk({pfx, "_r_id"},     64'(r_id_o),     64'd0);
        chk({pfx, "_r_data"},   r_data_o,        RESP_DATA);
        chk({pfx, "_err_cnt"},  64'(err_cnt_o),  64'd0);
        chk({pfx, "_err_addr"}, err_addr_o,      64'd0);
    endtask

    // AW handshake, nbeats W beats with last on the final one, b_ready held high.
    task automatic do_write(input string pfx, input logic [7:0] id, input logic [63:0] addr,
                            input int nbeats, input logic [15:0] exp_cnt);
        aw_id_i    = id;
        aw_addr_i  = addr;
        aw_valid_i = 1'b1;
        b_ready_i  = 1'b1;
        tick();
        aw_valid_i = 1'b0;
        chk({pfx, "_w_ready_n1"}, 64'(w_ready_o), 64'd1);
        chk({pfx, "_aw_ready_busy"}, 64'(aw_ready_o), 64'd0);
        chk({pfx, "_err_cnt"}, 64'(err_cnt_o), 64'(exp_cnt));
        chk({pfx, "_err_addr"}, err_addr_o, addr);
        w_valid_i = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            w_last_i = (i == nbeats - 1);
            chk({pfx, "_b_early"}, 64'(b_valid_o), 64'd0);
            tick();
        end
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        chk({pfx, "_b_valid"}, 64'(b_valid_o), 64'd1);
        chk({pfx, "_b_id"},    64'(b_id_o),    64'(id));
        chk({pfx, "_b_resp"},  64'(b_resp_o),  64'd3);
        chk({pfx, "_w_ready_resp"}, 64'(w_ready_o), 64'd0);
        tick();
        chk({pfx, "_b_done"},  64'(b_valid_o), 64'd0);
        chk({pfx, "_aw_idle"}, 64'(aw_ready_o), 64'd1);
    endtask

    // AR handshake then collect the burst; r_ready alternates 1,0,1,... when toggle is set.
    task automatic read_burst(input string pfx, input logic [7:0] id, input logic [7:0] len,
                              input bit toggle, input logic [63:0] addr, input logic [15:0] exp_cnt);
        int beats = 0;
        int bad   = 0;
        int cyc   = 0;
        ar_id_i    = id;
        ar_len_i   = len;
        ar_addr_i  = addr;
        ar_valid_i = 1'b1;
        tick();
        ar_valid_i = 1'b0;
        chk({pfx, "_r_valid_n1"}, 64'(r_valid_o), 64'd1);
        chk({pfx, "_err_cnt"}, 64'(err_cnt_o), 64'(exp_cnt));
        chk({pfx, "_err_addr"}, err_addr_o, addr);
        while (r_valid_o && cyc < 600) begin
            r_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
            if (r_last_o !== (beats == int'(len))) bad++;
            if (r_data_o !== RESP_DATA || r_resp_o !== 2'b11 || r_id_o !== id) bad++;
            if (r_ready_i) beats++;
            tick();
            cyc++;
        end
        r_ready_i = 1'b0;
        chk({pfx, "_beats"}, 64'(beats), 64'(int'(len) + 1));
        chk({pfx, "_beat_errs"}, 64'(bad), 64'd0);
        chk({pfx, "_ar_idle"}, 64'(ar_ready_o), 64'd1);
    endtask

    initial begin
        int seen;
        rst_ni     = 1'b0;
        aw_valid_i = 1'b0; aw_id_i = '0; aw_addr_i = '0;
        w_valid_i  = 1'b0; w_last_i = 1'b0;
        b_ready_i  = 1'b0;
        ar_valid_i = 1'b0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0;
        r_ready_i  = 1'b0;
        tick();
        tick();
        check_reset("rst");
        rst_ni = 1'b1;
        tick();

        // W beat without a prior AW must be refused
        w_valid_i = 1'b1;
        w_last_i  = 1'b1;
        chk("early_w_ready", 64'(w_ready_o), 64'd0);
        tick();
        chk("early_w_ready2", 64'(w_ready_o), 64'd0);
        chk("early_w_no_b", 64'(b_valid_o), 64'd0);
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;

        // basic write, three beats
        do_write("wr1", 8'h2A, 64'hF000_0000, 3, 16'd1);

        // four-beat read with throttled r_ready
        read_burst("rd1", 8'h05, 8'd3, 1'b1, 64'hE000_0040, 16'd2);

        // concurrent AW and AR in the same cycle
        aw_id_i = 8'h11; aw_addr_i = 64'hAAAA_0000; aw_valid_i = 1'b1;
        ar_id_i = 8'h22; ar_addr_i = 64'hBBBB_0000; ar_len_i = 8'd0; ar_valid_i = 1'b1;
        tick();
        aw_valid_i = 1'b0;
        ar_valid_i = 1'b0;
        chk("both_err_cnt",  64'(err_cnt_o), 64'd4);
        chk("both_err_addr", err_addr_o, 64'hAAAA_0000);
        chk("both_w_ready",  64'(w_ready_o), 64'd1);
        chk("both_r_valid",  64'(r_valid_o), 64'd1);
        chk("both_r_last",   64'(r_last_o),  64'd1);
        chk("both_r_id",     64'(r_id_o),    64'h22);
        w_valid_i = 1'b1; w_last_i = 1'b1; r_ready_i = 1'b1; b_ready_i = 1'b1;
        tick();
        w_valid_i = 1'b0; w_last_i = 1'b0; r_ready_i = 1'b0;
        chk("both_r_done",  64'(r_valid_o), 64'd0);
        chk("both_b_valid", 64'(b_valid_o), 64'd1);
        chk("both_b_id",    64'(b_id_o),    64'h11);
        tick();
        chk("both_b_done",  64'(b_valid_o), 64'd0);

        // maximum-length burst
        read_burst("rd256", 8'h7F, 8'd255, 1'b0, 64'hC000_1000, 16'd5);

        // reset while a write is draining and a read is sending
        b_ready_i = 1'b0;
        aw_id_i = 8'h33; aw_addr_i = 64'h1234_0000; aw_valid_i = 1'b1;
        ar_id_i = 8'h44; ar_addr_i = 64'h5678_0000; ar_len_i = 8'd3; ar_valid_i = 1'b1;
        tick();
        aw_valid_i = 1'b0;
        ar_valid_i = 1'b0;
        w_valid_i  = 1'b1;
        w_last_i   = 1'b0;
        tick();
        w_valid_i  = 1'b0;
        chk("mid_w_ready", 64'(w_ready_o), 64'd1);
        chk("mid_r_valid", 64'(r_valid_o), 64'd1);
        rst_ni = 1'b0;
        #2;
        check_reset("midrst");
        tick();
        rst_ni    = 1'b1;
        b_ready_i = 1'b1;
        r_ready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (b_valid_o || r_valid_o) seen++;
            tick();
        end
        r_ready_i = 1'b0;
        chk("post_rst_no_resp", 64'(seen), 64'd0);
        do_write("wr2", 8'h5A, 64'h9000_0000, 1, 16'd1);
        read_burst("rd2", 8'h66, 8'd0, 1'b0, 64'h9000_0100, 16'd2);

        // saturation of the error counter
        force dut.err_cnt_q = 16'hFFFD;
        #1;
        release dut.err_cnt_q;
        #1;
        chk("sat_preload", 64'(err_cnt_o), 64'hFFFD);
        aw_id_i = 8'h01; aw_addr_i = 64'hDEAD_0000; aw_valid_i = 1'b1;
        ar_id_i = 8'h02; ar_addr_i = 64'hBEEF_0000; ar_len_i = 8'd0; ar_valid_i = 1'b1;
        tick();
        aw_valid_i = 1'b0;
        ar_valid_i = 1'b0;
        chk("sat_exact", 64'(err_cnt_o), 64'hFFFF);
        w_valid_i = 1'b1; w_last_i = 1'b1; r_ready_i = 1'b1; b_ready_i = 1'b1;
        tick();
        w_valid_i = 1'b0; w_last_i = 1'b0; r_ready_i = 1'b0;
        tick();
        read_burst("sat_rd", 8'h03, 8'd0, 1'b0, 64'h0000_00C0, 16'hFFFF);
        aw_id_i = 8'h04; aw_addr_i = 64'h0000_00D0; aw_valid_i = 1'b1;
        ar_id_i = 8'h05; ar_addr_i = 64'h0000_00E0; ar_len_i = 8'd0; ar_valid_i = 1'b1;
        tick();
        aw_valid_i = 1'b0;
        ar_valid_i = 1'b0;
        chk("sat_hold2", 64'(err_cnt_o), 64'hFFFF);
        chk("sat_addr",  err_addr_o, 64'h0000_00D0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
